// File: rtl/leaf_user_rx_fifo.sv
// leaf_user_rx_fifo
// Receive-side buffer between a leaf interface and a user kernel. A rising
// edge on ap_start arms a transfer of num_words words. Words are accepted
// from the leaf interface into a first-word-fall-through FIFO until the
// requested count is reached. done pulses once after the last word drains.

module leaf_user_rx_fifo #(
    parameter int PAYLOAD_BITS = 32,
    parameter int DEPTH_BITS   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ap_start,
    input  logic [31:0]             num_words,
    input  logic [PAYLOAD_BITS-1:0] din_leaf_interface2user,
    input  logic                    vld_interface2user,
    output logic                    ack_user2interface,
    output logic [PAYLOAD_BITS-1:0] dout,
    output logic                    dout_vld,
    input  logic                    dout_rdy,
    output logic [31:0]             word_cnt,
    output logic [DEPTH_BITS:0]     occupancy,
    output logic                    done
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] FULL_LEVEL = {1'b1, {DEPTH_BITS{1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    apStart_q;
    logic                    startBlock_q;
    logic [DEPTH_BITS-1:0]   wrPtr_q;
    logic [DEPTH_BITS-1:0]   rdPtr_q;
    logic [DEPTH_BITS:0]     occ_q;
    logic [31:0]             wordCnt_q;
    logic [31:0]             numWords_q;
    logic [PAYLOAD_BITS-1:0] mem [DEPTH];

    logic start;
    logic full;
    logic push;
    logic pop;

    // Start is a rising edge of ap_start; a level that was already high
    // during reset is ignored until ap_start has gone low again.
    assign start = ap_start & ~apStart_q & ~startBlock_q;
    assign full  = (occ_q == FULL_LEVEL);

    // Accept only while running, with room left and words still owed; a
    // start cycle flushes everything, so nothing is accepted then either.
    assign ack_user2interface = ~reset & (state_q == RUN) & ~full
                              & (wordCnt_q < numWords_q) & ~start;

    assign dout_vld  = ~reset & (occ_q != '0);
    assign dout      = dout_vld ? mem[rdPtr_q] : '0;
    assign done      = ~reset & (state_q == DONE);
    assign word_cnt  = wordCnt_q;
    assign occupancy = occ_q;

    assign push = vld_interface2user & ack_user2interface;
    assign pop  = dout_vld & dout_rdy;

    // Edge detector history plus the guard that suppresses a start caused
    // by ap_start being held high across reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            apStart_q    <= 1'b0;
            startBlock_q <= ap_start;
        end else begin
            apStart_q    <= ap_start;
            startBlock_q <= startBlock_q & ap_start;
        end
    end

    // Storage array; no reset needed because dout is masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr_q] <= din_leaf_interface2user;
        end
    end

    // FIFO pointers and fill level; a start flushes the buffer outright.
    always_ff @(posedge clk) begin
        if (reset || start) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            occ_q   <= '0;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Transfer bookkeeping: words accepted so far and the requested total.
    always_ff @(posedge clk) begin
        if (reset) begin
            wordCnt_q  <= '0;
            numWords_q <= '0;
        end else if (start) begin
            wordCnt_q  <= '0;
            numWords_q <= num_words;
        end else if (push) begin
            wordCnt_q  <= wordCnt_q + 32'd1;
        end
    end

    // Transfer control: RUN until every requested word has been accepted
    // and drained, then one DONE cycle, then back to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else if (start) begin
            state_q <= RUN;
        end else begin
            case (state_q)
                IDLE: state_q <= IDLE;
                RUN: begin
                    if ((wordCnt_q == numWords_q) && (occ_q == '0)) begin
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_leaf_user_rx_fifo.sv
// Testbench for leaf_user_rx_fifo: a hand-derived vector table, directed
// corner sequences and a randomized run, all against a queue-based model.

module tb_leaf_user_rx_fifo;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ap_start = 1'b0;
    logic [31:0] num_words = '0;
    logic [31:0] din = '0;
    logic        vld = 1'b0;
    logic        dout_rdy = 1'b0;
    logic        ack;
    logic [31:0] dout;
    logic        dout_vld;
    logic [31:0] word_cnt;
    logic [4:0]  occupancy;
    logic        done;

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    leaf_user_rx_fifo #(.PAYLOAD_BITS(32), .DEPTH_BITS(4)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .ap_start                (ap_start),
        .num_words               (num_words),
        .din_leaf_interface2user (din),
        .vld_interface2user      (vld),
        .ack_user2interface      (ack),
        .dout                    (dout),
        .dout_vld                (dout_vld),
        .dout_rdy                (dout_rdy),
        .word_cnt                (word_cnt),
        .occupancy               (occupancy),
        .done                    (done)
    );

    int nCompared   = 0;
    int nMismatched = 0;

    // Reference model: the buffered words as a queue plus transfer status.
    logic [31:0] mQ[$];
    int          mCnt = 0;
    int          mTarget = 0;
    bit          mActive = 0;
    bit          mDoneNow = 0;
    bit          mPrevStart = 0;
    bit          mBlock = 0;
    bit          mPushed = 0;
    logic [31:0] expOut = '0;

    typedef struct {
        bit          rst;
        bit          ap;
        logic [31:0] num;
        bit          v;
        logic [31:0] d;
        bit          rdy;
        bit          eAck;
        bit          eVld;
        logic [31:0] eDout;
        int          eOcc;
        int          eCnt;
        bit          eDone;
    } vec_t;

    vec_t vecs[17];

    function automatic bit modelStart();
        return !reset && ap_start && !mPrevStart && !mBlock;
    endfunction

    function automatic bit modelAck();
        return !reset && mActive && (mQ.size() < DEPTH) && (mCnt < mTarget) && !modelStart();
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkModel();
        bit          eVld;
        logic [31:0] eDout;
        eVld  = !reset && (mQ.size() != 0);
        eDout = eVld ? mQ[0] : 32'h0;
        checkOutput("model_ack", 32'(ack), 32'(modelAck()));
        checkOutput("model_dout_vld", 32'(dout_vld), 32'(eVld));
        checkOutput("model_dout", dout, eDout);
        checkOutput("model_occupancy", 32'(occupancy), 32'(mQ.size()));
        checkOutput("model_word_cnt", word_cnt, 32'(mCnt));
        checkOutput("model_done", 32'(done), 32'(!reset && mDoneNow));
    endtask

    task automatic updateModel();
        bit st;
        bit pushNow;
        bit popNow;
        bit finishing;
        mPushed = 0;
        if (reset) begin
            mQ.delete();
            mCnt = 0;
            mTarget = 0;
            mActive = 0;
            mDoneNow = 0;
            mPrevStart = 0;
            mBlock = ap_start;
        end else begin
            st      = modelStart();
            pushNow = vld && modelAck();
            popNow  = dout_rdy && (mQ.size() != 0);
            mPrevStart = ap_start;
            mBlock = mBlock && ap_start;
            if (st) begin
                mQ.delete();
                mCnt = 0;
                mTarget = int'(num_words);
                mActive = 1;
                mDoneNow = 0;
            end else begin
                finishing = mActive && (mCnt == mTarget) && (mQ.size() == 0);
                mDoneNow = finishing;
                if (finishing) mActive = 0;
                if (popNow) void'(mQ.pop_front());
                if (pushNow) begin
                    mQ.push_back(din);
                    mCnt++;
                    mPushed = 1;
                end
            end
        end
    endtask

    // One clock cycle: settle, check against the model, clock, update model.
    task automatic applyStimulus();
        #1;
        checkModel();
        @(posedge clk);
        updateModel();
        #1;
    endtask

    task automatic orderCheck();
        if (!reset && dout_rdy && (mQ.size() != 0)) begin
            checkOutput("order", dout, expOut);
            expOut++;
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        ap_start = 1'b0;
        vld = 1'b0;
        dout_rdy = 1'b0;
        applyStimulus();
        applyStimulus();
        reset = 1'b0;
    endtask

    task automatic arm(input int n);
        ap_start = 1'b0;
        applyStimulus();
        ap_start = 1'b1;
        num_words = 32'(n);
        applyStimulus();
    endtask

    initial begin
        int accepts;
        int dones;

        // rst ap num v din rdy | ack vld dout occ cnt done
        vecs[0]  = '{1, 0, 0, 0, 32'h0,         0,  0, 0, 32'h0,         0, 0, 0};
        vecs[1]  = '{1, 1, 0, 0, 32'h0,         0,  0, 0, 32'h0,         0, 0, 0};
        vecs[2]  = '{0, 1, 0, 0, 32'h0,         0,  0, 0, 32'h0,         0, 0, 0};
        vecs[3]  = '{0, 0, 0, 0, 32'h0,         0,  0, 0, 32'h0,         0, 0, 0};
        vecs[4]  = '{0, 1, 0, 0, 32'h0,         0,  0, 0, 32'h0,         0, 0, 0};
        vecs[5]  = '{0, 1, 0, 0, 32'h0,         0,  0, 0, 32'h0,         0, 0, 0};
        vecs[6]  = '{0, 1, 0, 0, 32'h0,         0,  0, 0, 32'h0,         0, 0, 1};
        vecs[7]  = '{0, 0, 0, 0, 32'h0,         0,  0, 0, 32'h0,         0, 0, 0};
        vecs[8]  = '{0, 1, 2, 1, 32'hA5A50001, 0,  0, 0, 32'h0,         0, 0, 0};
        vecs[9]  = '{0, 1, 2, 1, 32'hA5A50001, 0,  1, 0, 32'h0,         0, 0, 0};
        vecs[10] = '{0, 1, 2, 1, 32'h5A5A0002, 0,  1, 1, 32'hA5A50001, 1, 1, 0};
        vecs[11] = '{0, 1, 2, 1, 32'hDEAD0003, 0,  0, 1, 32'hA5A50001, 2, 2, 0};
        vecs[12] = '{0, 1, 2, 0, 32'h0,         1,  0, 1, 32'hA5A50001, 2, 2, 0};
        vecs[13] = '{0, 1, 2, 0, 32'h0,         1,  0, 1, 32'h5A5A0002, 1, 2, 0};
        vecs[14] = '{0, 1, 2, 0, 32'h0,         1,  0, 0, 32'h0,         0, 2, 0};
        vecs[15] = '{0, 1, 2, 0, 32'h0,         1,  0, 0, 32'h0,         0, 2, 1};
        vecs[16] = '{0, 1, 2, 0, 32'h0,         1,  0, 0, 32'h0,         0, 2, 0};

        reset = 1'b1;
        repeat (2) @(posedge clk);
        updateModel();
        #1;

        // Table: reset, ap_start held through reset, zero-word transfer,
        // two-word transfer with back-pressure.
        for (int i = 0; i < 17; i++) begin
            reset     = vecs[i].rst;
            ap_start  = vecs[i].ap;
            num_words = vecs[i].num;
            vld       = vecs[i].v;
            din       = vecs[i].d;
            dout_rdy  = vecs[i].rdy;
            #1;
            checkOutput($sformatf("vec%0d_ack", i), 32'(ack), 32'(vecs[i].eAck));
            checkOutput($sformatf("vec%0d_dout_vld", i), 32'(dout_vld), 32'(vecs[i].eVld));
            checkOutput($sformatf("vec%0d_dout", i), dout, vecs[i].eDout);
            checkOutput($sformatf("vec%0d_occupancy", i), 32'(occupancy), 32'(vecs[i].eOcc));
            checkOutput($sformatf("vec%0d_word_cnt", i), word_cnt, 32'(vecs[i].eCnt));
            checkOutput($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].eDone));
            applyStimulus();
        end

        // Five words streamed with no back-pressure.
        doReset();
        dout_rdy = 1'b1;
        arm(5);
        vld = 1'b1;
        accepts = 0;
        dones = 0;
        for (int c = 0; c < 15; c++) begin
            din = $urandom;
            #1;
            if (ack && vld) accepts++;
            if (done) dones++;
            applyStimulus();
        end
        checkOutput("stream5_accepts", 32'(accepts), 32'd5);
        checkOutput("stream5_dones", 32'(dones), 32'd1);
        checkOutput("stream5_word_cnt", word_cnt, 32'd5);
        checkOutput("stream5_ack_after", 32'(ack), 32'd0);

        // Twenty words into a sixteen-deep FIFO, full-with-pop corner, drain.
        doReset();
        arm(20);
        vld = 1'b1;
        din = 32'd1;
        expOut = 32'd1;
        for (int c = 0; c < 20; c++) begin
            applyStimulus();
            if (mPushed) din = din + 32'd1;
        end
        #1;
        checkOutput("fill_occupancy", 32'(occupancy), 32'd16);
        checkOutput("fill_ack", 32'(ack), 32'd0);
        dout_rdy = 1'b1;
        #1;
        checkOutput("fullpop_ack", 32'(ack), 32'd0);
        orderCheck();
        applyStimulus();
        if (mPushed) din = din + 32'd1;
        dout_rdy = 1'b0;
        #1;
        checkOutput("fullpop_occupancy", 32'(occupancy), 32'd15);
        checkOutput("fullpop_ack_next", 32'(ack), 32'd1);
        applyStimulus();
        if (mPushed) din = din + 32'd1;
        #1;
        checkOutput("refill_occupancy", 32'(occupancy), 32'd16);
        dout_rdy = 1'b1;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            orderCheck();
            if (done) dones++;
            applyStimulus();
            if (mPushed) din = din + 32'd1;
        end
        checkOutput("drain20_last_word", expOut, 32'd21);
        checkOutput("drain20_dones", 32'(dones), 32'd1);
        checkOutput("drain20_word_cnt", word_cnt, 32'd20);

        // Re-arm while seven words are buffered.
        doReset();
        arm(12);
        vld = 1'b1;
        for (int c = 0; c < 7; c++) begin
            din = $urandom;
            applyStimulus();
        end
        vld = 1'b0;
        ap_start = 1'b0;
        applyStimulus();
        #1;
        checkOutput("rearm_pre_occupancy", 32'(occupancy), 32'd7);
        ap_start = 1'b1;
        num_words = 32'd3;
        applyStimulus();
        #1;
        checkOutput("rearm_occupancy", 32'(occupancy), 32'd0);
        checkOutput("rearm_dout_vld", 32'(dout_vld), 32'd0);
        checkOutput("rearm_word_cnt", word_cnt, 32'd0);
        vld = 1'b1;
        dout_rdy = 1'b1;
        accepts = 0;
        for (int c = 0; c < 10; c++) begin
            din = $urandom;
            #1;
            if (ack && vld) accepts++;
            applyStimulus();
        end
        checkOutput("rearm_accepts", 32'(accepts), 32'd3);

        // Reset in the middle of a transfer with four words buffered.
        doReset();
        arm(10);
        vld = 1'b1;
        for (int c = 0; c < 4; c++) begin
            din = $urandom;
            applyStimulus();
        end
        #1;
        checkOutput("midreset_pre_occupancy", 32'(occupancy), 32'd4);
        reset = 1'b1;
        #1;
        checkOutput("midreset_during_ack", 32'(ack), 32'd0);
        checkOutput("midreset_during_dout_vld", 32'(dout_vld), 32'd0);
        applyStimulus();
        reset = 1'b0;
        #1;
        checkOutput("midreset_occupancy", 32'(occupancy), 32'd0);
        checkOutput("midreset_dout_vld", 32'(dout_vld), 32'd0);
        checkOutput("midreset_ack", 32'(ack), 32'd0);
        dones = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (done) dones++;
            applyStimulus();
        end
        checkOutput("midreset_no_done", 32'(dones), 32'd0);

        // Randomized traffic, restarts and occasional resets.
        doReset();
        for (int c = 0; c < 3000; c++) begin
            reset    = ($urandom_range(0, 499) == 0);
            ap_start = ($urandom_range(0, 149) == 0) ? 1'b1
                     : (ap_start && ($urandom_range(0, 3) != 0));
            num_words = 32'($urandom_range(0, 40));
            vld      = ($urandom_range(0, 9) < 7);
            din      = $urandom;
            dout_rdy = ($urandom_range(0, 1) == 1);
            applyStimulus();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
